dcache_direct_mapped: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache.
- Responder side of the DCACHE_* interface driven by the pipelined CPU core: it accepts word requests and returns `proc_stall`/`proc_rdata`.
- Fills and evicts 128-bit blocks over a handshaked memory port.
- Sits between the core and the slow data memory.

---
 rtl/dcache_pkg.sv | 41 ++++
 rtl/dcache_line_array.sv | 68 ++++++
 rtl/dcache_direct_mapped.sv | 158 +++++++++++++++
 tb/tb_dcache_direct_mapped.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data cache: bus widths, controller
// state encoding and small helpers for picking a word out of a block or
// merging one in.
package dcache_pkg;

   localparam int WORD_W          = 32;
   localparam int BLOCK_W         = 128;
   localparam int OFFSET_W        = 2;
   localparam int PROC_ADDR_W     = 30;
   localparam int MEM_ADDR_W      = 28;
   localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;

   // Controller states. The encoding is fixed so external checkers can decode
   // the debug state output without importing this package.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_t;

   // Word k of a block lives in bits [32k+31:32k].
   function automatic logic [WORD_W-1:0] get_word(
      input logic [BLOCK_W-1:0]  blk,
      input logic [OFFSET_W-1:0] off
   );
      return blk[off*WORD_W +: WORD_W];
   endfunction

   // Return the block with word 'off' replaced; the other words are untouched.
   function automatic logic [BLOCK_W-1:0] put_word(
      input logic [BLOCK_W-1:0]  blk,
      input logic [OFFSET_W-1:0] off,
      input logic [WORD_W-1:0]   word
   );
      logic [BLOCK_W-1:0] merged;
      merged = blk;
      merged[off*WORD_W +: WORD_W] = word;
      return merged;
   endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Line storage for the direct-mapped cache: per-line valid, dirty, tag and a
// 128-bit data block. Reads are combinational by index; a single write port
// either fills a whole block (fresh, clean line) or merges one word (marks the
// line dirty). Only valid/dirty are reset; tag and data are don't-care until
// their line becomes valid.
module dcache_line_array
   import dcache_pkg::*;
#(
   parameter int NUM_BLOCKS = 8,
   parameter int INDEX_W    = $clog2(NUM_BLOCKS),
   parameter int TAG_W      = PROC_ADDR_W - OFFSET_W - INDEX_W
) (
   input  logic                clk,
   input  logic                rst,
   // shared read/write index
   input  logic [INDEX_W-1:0]  index,
   // block fill from memory
   input  logic                fill_en,
   input  logic [TAG_W-1:0]    fill_tag,
   input  logic [BLOCK_W-1:0]  fill_data,
   // single-word store from the core
   input  logic                merge_en,
   input  logic [OFFSET_W-1:0] merge_offset,
   input  logic [WORD_W-1:0]   merge_word,
   // combinational read of the indexed line
   output logic                line_valid,
   output logic                line_dirty,
   output logic [TAG_W-1:0]    line_tag,
   output logic [BLOCK_W-1:0]  line_data
);

   logic [NUM_BLOCKS-1:0] valid_q;
   logic [NUM_BLOCKS-1:0] dirty_q;
   logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
   logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

   // Status bits: async clear; a fill makes the line valid and clean, a merge dirties it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_en) begin
         valid_q[index] <= 1'b1;
         dirty_q[index] <= 1'b0;
      end else if (merge_en) begin
         dirty_q[index] <= 1'b1;
      end
   end

   // Tag and data storage: no reset, contents qualified by the valid bit.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_q[index]  <= fill_tag;
         data_q[index] <= fill_data;
      end else if (merge_en) begin
         data_q[index] <= put_word(data_q[index], merge_offset, merge_word);
      end
   end

   // Combinational read port.
   always_comb begin
      line_valid = valid_q[index];
      line_dirty = dirty_q[index];
      line_tag   = tag_q[index];
      line_data  = data_q[index];
   end

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate data cache between the pipelined
// core and the slow data memory.
//
// Handshakes:
//   core side  - a request (proc_read/proc_write) is held stable by the core
//                while proc_stall=1; it completes in the first cycle where
//                proc_stall=0 (read data valid in that cycle, a store is
//                written on the closing clock edge).
//   memory side - mem_read or mem_write, together with mem_addr/mem_wdata, is
//                held stable until the cycle in which mem_ready pulses; that
//                cycle completes the transfer (fill data sampled from
//                mem_rdata on the same edge). mem_ready at any other time is
//                ignored.
module dcache_direct_mapped
   import dcache_pkg::*;
#(
   parameter int NUM_BLOCKS = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   proc_read,
   input  logic                   proc_write,
   input  logic [PROC_ADDR_W-1:0] proc_addr,
   input  logic [WORD_W-1:0]      proc_wdata,
   output logic                   proc_stall,
   output logic [WORD_W-1:0]      proc_rdata,
   output logic                   mem_read,
   output logic                   mem_write,
   output logic [MEM_ADDR_W-1:0]  mem_addr,
   output logic [BLOCK_W-1:0]     mem_wdata,
   input  logic [BLOCK_W-1:0]     mem_rdata,
   input  logic                   mem_ready,
   output state_t                 dbg_state
);

   localparam int INDEX_W = $clog2(NUM_BLOCKS);
   localparam int TAG_W   = PROC_ADDR_W - OFFSET_W - INDEX_W;

   // Request address fields.
   logic [OFFSET_W-1:0] req_offset;
   logic [INDEX_W-1:0]  req_index;
   logic [TAG_W-1:0]    req_tag;

   // Indexed line as seen by the compare logic.
   logic                line_valid;
   logic                line_dirty;
   logic [TAG_W-1:0]    line_tag;
   logic [BLOCK_W-1:0]  line_data;

   // Array write controls.
   logic                fill_en;
   logic                merge_en;

   logic                req;
   logic                hit;

   state_t              state_q;
   state_t              state_d;

   assign req_offset = proc_addr[OFFSET_W-1:0];
   assign req_index  = proc_addr[OFFSET_W +: INDEX_W];
   assign req_tag    = proc_addr[PROC_ADDR_W-1 -: TAG_W];

   assign req = proc_read | proc_write;
   assign hit = line_valid & (line_tag == req_tag);

   assign dbg_state = state_q;

   dcache_line_array #(
      .NUM_BLOCKS (NUM_BLOCKS),
      .INDEX_W    (INDEX_W),
      .TAG_W      (TAG_W)
   ) u_lines (
      .clk          (clk),
      .rst          (rst),
      .index        (req_index),
      .fill_en      (fill_en),
      .fill_tag     (req_tag),
      .fill_data    (mem_rdata),
      .merge_en     (merge_en),
      .merge_offset (req_offset),
      .merge_word   (proc_wdata),
      .line_valid   (line_valid),
      .line_dirty   (line_dirty),
      .line_tag     (line_tag),
      .line_data    (line_data)
   );

   // Controller state register; reset aborts any memory transfer in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and output decode. Memory strobes depend only on the
   // registered state so they cannot glitch and are never high together.
   always_comb begin
      state_d    = state_q;
      proc_stall = 1'b0;
      proc_rdata = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      fill_en    = 1'b0;
      merge_en   = 1'b0;

      case (state_q)
         IDLE: begin
            // rst also gates the stall so the core sees a quiet cache while
            // reset is held, even if it keeps a request up.
            proc_stall = ~rst & req & ~hit;
            if (hit && proc_write) begin
               merge_en = 1'b1;
            end
            if (hit && proc_read && !proc_write) begin
               proc_rdata = get_word(line_data, req_offset);
            end
            if (req && !hit) begin
               // Only a dirty victim needs to go back to memory first.
               state_d = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
            end
         end

         WRITEBACK: begin
            // The victim is read live from the array; nothing writes this
            // line until the fill, so address and data stay stable.
            proc_stall = 1'b1;
            mem_write  = 1'b1;
            mem_addr   = {line_tag, req_index};
            mem_wdata  = line_data;
            if (mem_ready) begin
               state_d = ALLOCATE;
            end
         end

         ALLOCATE: begin
            proc_stall = 1'b1;
            mem_read   = 1'b1;
            mem_addr   = proc_addr[PROC_ADDR_W-1:OFFSET_W];
            if (mem_ready) begin
               // Install the block clean; the following IDLE cycle re-compares
               // and then serves the read or merges the store.
               fill_en = 1'b1;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed bench for the direct-mapped data cache. Requests are issued by a
// driver task that also pushes the expected read data and expected memory
// transactions; two monitors (read completions, memory port) pop and compare.
// A small memory model answers fills and absorbs writebacks after a fixed
// latency.
module tb_dcache_direct_mapped;
   import dcache_pkg::*;

   localparam int MEM_LAT   = 3;
   localparam int STALL_MAX = 50;
   localparam int MEM_EXP_W = 1 + MEM_ADDR_W + BLOCK_W;

   logic                   clk;
   logic                   rst;
   logic                   proc_read;
   logic                   proc_write;
   logic [PROC_ADDR_W-1:0] proc_addr;
   logic [WORD_W-1:0]      proc_wdata;
   logic                   proc_stall;
   logic [WORD_W-1:0]      proc_rdata;
   logic                   mem_read;
   logic                   mem_write;
   logic [MEM_ADDR_W-1:0]  mem_addr;
   logic [BLOCK_W-1:0]     mem_wdata;
   logic [BLOCK_W-1:0]     mem_rdata;
   logic                   mem_ready;
   state_t                 dbg_state;

   int checks = 0;
   int errors = 0;

   // Scoreboard queues: read data, and memory transactions {is_write, addr, wdata}.
   logic [WORD_W-1:0]    exp_rd_q[$];
   logic [MEM_EXP_W-1:0] exp_mem_q[$];

   // Backing store keyed by block address; absent blocks read as zero.
   logic [BLOCK_W-1:0] mem_model [logic [MEM_ADDR_W-1:0]];

   dcache_direct_mapped #(.NUM_BLOCKS(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_stall (proc_stall),
      .proc_rdata (proc_rdata),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [MEM_EXP_W-1:0] mem_txn(input logic wr, input logic [MEM_ADDR_W-1:0] a,
                                                    input logic [BLOCK_W-1:0] d);
      return {wr, a, d};
   endfunction

   // ---------------- driver ----------------
   // Issue one request right after a rising edge, hold it while stalled, and
   // check the number of stalled cycles before completion.
   task automatic do_req(input string name, input logic wr, input logic [PROC_ADDR_W-1:0] addr,
                         input logic [WORD_W-1:0] wdata, input int exp_stall);
      int  n;
      bit  done;
      proc_addr  = addr;
      proc_wdata = wdata;
      proc_write = wr;
      proc_read  = ~wr;
      n    = 0;
      done = 1'b0;
      while (!done && n < STALL_MAX) begin
         @(negedge clk);
         if (proc_stall) n++;
         else done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: still stalled after %0d cycles, required %0d", name, n, exp_stall);
      end else begin
         check({name, " stall_cycles"}, 160'(n), 160'(exp_stall));
      end
      @(posedge clk);
      #1;
      proc_read  = 1'b0;
      proc_write = 1'b0;
   endtask

   task automatic do_read(input string name, input logic [PROC_ADDR_W-1:0] addr,
                          input logic [WORD_W-1:0] exp_data, input int exp_stall);
      exp_rd_q.push_back(exp_data);
      do_req(name, 1'b0, addr, '0, exp_stall);
   endtask

   task automatic do_write(input string name, input logic [PROC_ADDR_W-1:0] addr,
                           input logic [WORD_W-1:0] data, input int exp_stall);
      do_req(name, 1'b1, addr, data, exp_stall);
   endtask

   // ---------------- read monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && proc_read && !proc_write && !proc_stall) begin
            if (exp_rd_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rdata_unexpected: got %0h with no read expected", proc_rdata);
            end else begin
               check("rdata", 160'(proc_rdata), 160'(exp_rd_q.pop_front()));
            end
         end
      end
   end

   // ---------------- memory model + monitor ----------------
   initial begin
      int                    cnt;
      logic [MEM_EXP_W-1:0]  exp;
      logic [159:0]          held;
      mem_ready = 1'b0;
      mem_rdata = '0;
      cnt       = 0;
      held      = '0;
      forever begin
         @(negedge clk);
         if (mem_ready) begin
            mem_ready = 1'b0;
            cnt       = 0;
         end
         if (rst) begin
            cnt = 0;
         end else if (mem_read || mem_write) begin
            check("mem_exclusive", 160'(mem_read & mem_write), 160'(0));
            if (cnt == 0) begin
               if (exp_mem_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL mem_unexpected: got wr=%0b addr=%0h with no transfer expected",
                           mem_write, mem_addr);
               end else begin
                  exp = exp_mem_q.pop_front();
                  check("mem_kind", 160'(mem_write), 160'(exp[MEM_EXP_W-1]));
                  check("mem_addr", 160'(mem_addr), 160'(exp[MEM_ADDR_W+BLOCK_W-1:BLOCK_W]));
                  if (exp[MEM_EXP_W-1]) check("mem_wdata", 160'(mem_wdata), 160'(exp[BLOCK_W-1:0]));
               end
               held = {mem_read, mem_write, 2'b00, mem_addr, mem_wdata};
            end else begin
               check("mem_hold", {mem_read, mem_write, 2'b00, mem_addr, mem_wdata}, held);
            end
            cnt++;
            if (cnt == MEM_LAT) begin
               if (mem_write) begin
                  mem_model[mem_addr] = mem_wdata;
               end else begin
                  mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : '0;
               end
               mem_ready = 1'b1;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      rst        = 1'b1;
      proc_read  = 1'b1;   // request held during reset must not raise a stall
      proc_write = 1'b0;
      proc_addr  = 30'h10;
      proc_wdata = '0;

      mem_model[28'h4]  = 128'h44443333_22221111_00000000_CCCCBBBB;
      mem_model[28'hC]  = 128'h0000000D_0000000C_0000000B_0000000A;
      mem_model[28'h11] = 128'h11111111_22222222_33333333_44444444;
      mem_model[28'h14] = 128'h00000000_00000000_00000000_50505050;

      // Reset state.
      @(negedge clk);
      check("rst mem_read",   160'(mem_read),   160'(0));
      check("rst mem_write",  160'(mem_write),  160'(0));
      check("rst mem_addr",   160'(mem_addr),   160'(0));
      check("rst mem_wdata",  160'(mem_wdata),  160'(0));
      check("rst proc_stall", 160'(proc_stall), 160'(0));
      check("rst proc_rdata", 160'(proc_rdata), 160'(0));
      check("rst state",      160'(dbg_state),  160'(IDLE));
      proc_read = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;

      // Cold read miss: addr 0x10 -> index 4, tag 0, block 0x4, word 0.
      exp_mem_q.push_back(mem_txn(1'b0, 28'h4, '0));
      do_read("cold_miss 0x10", 30'h10, 32'hCCCCBBBB, 4);
      do_read("hit 0x11", 30'h11, 32'h00000000, 0);
      do_read("hit 0x13", 30'h13, 32'h44443333, 0);

      // Write hit, then read it back; no memory traffic expected.
      do_write("write_hit 0x12", 30'h12, 32'hDEADBEEF, 0);
      do_read("hit 0x12", 30'h12, 32'hDEADBEEF, 0);

      // Dirty eviction: 0x32 -> index 4, tag 1, block 0xC, word 2.
      exp_mem_q.push_back(mem_txn(1'b1, 28'h4, 128'h44443333_DEADBEEF_00000000_CCCCBBBB));
      exp_mem_q.push_back(mem_txn(1'b0, 28'hC, '0));
      do_read("dirty_evict 0x32", 30'h32, 32'h0000000C, 7);

      // Clean conflict misses: line is clean, so fill only.
      exp_mem_q.push_back(mem_txn(1'b0, 28'h4, '0));
      do_read("clean_conflict 0x10", 30'h10, 32'hCCCCBBBB, 4);
      do_read("written_back 0x12", 30'h12, 32'hDEADBEEF, 0);
      exp_mem_q.push_back(mem_txn(1'b0, 28'hC, '0));
      do_read("clean_conflict 0x30", 30'h30, 32'h0000000A, 4);

      // Write miss allocate: 0x45 -> index 1, tag 2, block 0x11, word 1.
      exp_mem_q.push_back(mem_txn(1'b0, 28'h11, '0));
      do_write("write_miss 0x45", 30'h45, 32'h00000055, 4);
      do_read("merged 0x45", 30'h45, 32'h00000055, 0);
      // Conflicting read 0x25 (index 1, tag 1) evicts the merged dirty line.
      exp_mem_q.push_back(mem_txn(1'b1, 28'h11, 128'h11111111_22222222_00000055_44444444));
      exp_mem_q.push_back(mem_txn(1'b0, 28'h9, '0));
      do_read("evict_merged 0x25", 30'h25, 32'h00000000, 7);

      // Reset in the middle of a fill of 0x50 (index 4, tag 2, block 0x14).
      exp_mem_q.push_back(mem_txn(1'b0, 28'h14, '0));
      proc_addr = 30'h50;
      proc_read = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_read && n < 20);
      check("alloc mem_read", 160'(mem_read), 160'(1));
      check("alloc state", 160'(dbg_state), 160'(ALLOCATE));
      #1 rst = 1'b1;
      #1;
      check("async mem_read", 160'(mem_read), 160'(0));
      check("async mem_write", 160'(mem_write), 160'(0));
      check("async mem_addr", 160'(mem_addr), 160'(0));
      check("async proc_stall", 160'(proc_stall), 160'(0));
      check("async state", 160'(dbg_state), 160'(IDLE));
      proc_read = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // Every line was invalidated: both the aborted address and an older one miss.
      exp_mem_q.push_back(mem_txn(1'b0, 28'h14, '0));
      do_read("after_rst 0x50", 30'h50, 32'h50505050, 4);
      exp_mem_q.push_back(mem_txn(1'b0, 28'h4, '0));
      do_read("after_rst 0x12", 30'h12, 32'hDEADBEEF, 4);

      repeat (3) @(posedge clk);
      check("rd_q drained", 160'(exp_rd_q.size()), 160'(0));
      check("mem_q drained", 160'(exp_mem_q.size()), 160'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
